// File: rtl/mux_scan_sequencer_if.sv
// Handshake and select bundle between mux_scan_sequencer and its environment.
// The slave modport is the sequencer; the master modport is the driving side.
interface mux_scan_sequencer_if;
  logic       start;
  logic       stop;
  logic [3:0] ch_mask;
  logic       mux_out;
  logic       s1;
  logic       s2;
  logic [3:0] samples;
  logic       frame_valid;
  logic       frame_ready;
  logic       busy;

  modport master (
    output start, stop, ch_mask, mux_out, frame_ready,
    input  s1, s2, samples, frame_valid, busy
  );

  modport slave (
    input  start, stop, ch_mask, mux_out, frame_ready,
    output s1, s2, samples, frame_valid, busy
  );
endinterface

// File: rtl/mux_scan_sequencer.sv
// Walks the 4:1 mux selects over enabled channels, dwells, samples and emits a frame.
// Define MUX_SCAN_CONTINUOUS_EN to rescan back-to-back after each accepted frame.
module mux_scan_sequencer #(
  parameter int unsigned DWELL = 4,
  parameter int unsigned CNT_W = 8
) (
  input logic                 clk,
  input logic                 rst,
  mux_scan_sequencer_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StSettle, StSample, StDone} state_e;

  state_e           state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       mask;
  logic [1:0]       sel;
  logic [3:0]       samples;
  logic             frame_valid;
  logic             busy;
  logic [2:0]       first_new;
  logic [2:0]       next_en;

  // Returns {found, index} of the lowest set bit of m at or above position from.
  function automatic logic [2:0] first_from(input logic [3:0] m, input int from);
    logic [2:0] r;
    r = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      if (m[i] && (i >= from)) r = {1'b1, 2'(i)};
    end
    return r;
  endfunction

  assign first_new = first_from(bus.ch_mask, 0);
  assign next_en   = first_from(mask, int'(sel) + 1);

  assign bus.s1          = sel[1];
  assign bus.s2          = sel[0];
  assign bus.samples     = samples;
  assign bus.frame_valid = frame_valid;
  assign bus.busy        = busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= StIdle;
      cnt         <= '0;
      mask        <= '0;
      sel         <= '0;
      samples     <= '0;
      frame_valid <= 1'b0;
      busy        <= 1'b0;
    end else begin
      unique case (state)
        StIdle: begin
          if (bus.start && !bus.stop && first_new[2]) begin
            mask    <= bus.ch_mask;
            samples <= '0;
            sel     <= first_new[1:0];
            cnt     <= '0;
            busy    <= 1'b1;
            state   <= StSettle;
          end
        end
        StSettle: begin
          if (bus.stop) begin
            samples <= '0;
            sel     <= '0;
            cnt     <= '0;
            busy    <= 1'b0;
            state   <= StIdle;
          end else begin
            cnt <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(DWELL - 1)) state <= StSample;
          end
        end
        StSample: begin
          if (bus.stop) begin
            samples <= '0;
            sel     <= '0;
            cnt     <= '0;
            busy    <= 1'b0;
            state   <= StIdle;
          end else begin
            samples[sel] <= bus.mux_out;
            if (next_en[2]) begin
              sel   <= next_en[1:0];
              cnt   <= '0;
              state <= StSettle;
            end else begin
              frame_valid <= 1'b1;
              state       <= StDone;
            end
          end
        end
        StDone: begin
          // Frame and selects stay frozen until the consumer takes it; stop is ignored here.
          if (bus.frame_ready) begin
            frame_valid <= 1'b0;
`ifdef MUX_SCAN_CONTINUOUS_EN
            mask <= bus.ch_mask;
            if (!bus.stop && first_new[2]) begin
              samples <= '0;
              sel     <= first_new[1:0];
              cnt     <= '0;
              state   <= StSettle;
            end else begin
              sel   <= '0;
              cnt   <= '0;
              busy  <= 1'b0;
              state <= StIdle;
            end
`else
            sel   <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
            state <= StIdle;
`endif
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Self-checking bench for mux_scan_sequencer: directed scenarios plus randomized traffic
// compared every cycle against a timeline model of the scan.
module tb_mux_scan_sequencer;
  localparam int unsigned DWELL = 4;
  localparam int          SLOT  = DWELL + 1;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] p;
  int         n_checks = 0;
  int         n_pass   = 0;

  mux_scan_sequencer_if bus ();

  mux_scan_sequencer #(.DWELL(DWELL), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.mux_out = p[{bus.s1, bus.s2}];

  always #5 clk = ~clk;

  // Model: phase 0 idle, 1 scanning, 2 frame pending; t counts edges since the scan started.
  int         phase;
  int         t;
  int         chans[$];
  logic [1:0] m_sel;
  logic [3:0] m_samples;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    phase = 0; t = 0; chans.delete(); m_sel = 2'd0; m_samples = 4'd0;
  endtask

  task automatic load_scan(input logic [3:0] mk);
    chans.delete();
    for (int i = 0; i < 4; i++) if (mk[i]) chans.push_back(i);
    t = 0; phase = 1; m_samples = 4'd0; m_sel = 2'(chans[0]);
  endtask

  task automatic model_step(input logic st, input logic sp, input logic [3:0] mk,
                            input logic rdy, input logic [3:0] pp);
    int k;
    case (phase)
      0: if (st && !sp && mk != 4'd0) load_scan(mk);
      1: begin
        if (sp) begin
          phase = 0; m_samples = 4'd0; m_sel = 2'd0;
        end else begin
          t++;
          if (t % SLOT == 0) begin
            k = t / SLOT - 1;
            m_samples[chans[k]] = pp[chans[k]];
            if (k + 1 == chans.size()) phase = 2;
          end
          if (phase == 1) m_sel = 2'(chans[t / SLOT]);
        end
      end
      default: begin
        if (rdy) begin
`ifdef MUX_SCAN_CONTINUOUS_EN
          if (!sp && mk != 4'd0) load_scan(mk);
          else begin phase = 0; m_sel = 2'd0; end
`else
          phase = 0; m_sel = 2'd0;
`endif
        end
      end
    endcase
  endtask

  task automatic check_all(input string pfx);
    check({pfx, "_sel"}, 32'({bus.s1, bus.s2}), 32'(m_sel));
    check({pfx, "_samples"}, 32'(bus.samples), 32'(m_samples));
    check({pfx, "_valid"}, 32'(bus.frame_valid), 32'(phase == 2));
    check({pfx, "_busy"}, 32'(bus.busy), 32'(phase != 0));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step(bus.start, bus.stop, bus.ch_mask, bus.frame_ready, p);
    #1;
    check_all("cyc");
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!bus.frame_valid && n < 200) begin
      cycle();
      n++;
    end
  endtask

  task automatic async_reset(input string tag);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all(tag);
    @(negedge clk);
    rst = 1'b0;
  endtask

  int n;
  int rises[$];
  logic prev_v;
  logic [3:0] held;

  initial begin
    rst = 1'b1;
    bus.start = 1'b0; bus.stop = 1'b0; bus.ch_mask = 4'd0; bus.frame_ready = 1'b0;
    p = 4'd0;
    model_reset();
    #2;
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;

    // 1: all channels, one frame with ready high
    p = 4'b0101; bus.ch_mask = 4'b1111; bus.frame_ready = 1'b1; bus.start = 1'b1;
    cycle();
    bus.start = 1'b0;
    wait_valid(n);
    check("t1_latency", 32'(n), 32'd20);
    check("t1_samples", 32'(bus.samples), 32'b0101);
    cycle();
    check("t1_idle", 32'(bus.busy), 32'd0);

    // 2: sparse mask
    p = 4'b1111; bus.ch_mask = 4'b1010; bus.start = 1'b1;
    cycle();
    bus.start = 1'b0;
    wait_valid(n);
    check("t2_latency", 32'(n), 32'd10);
    check("t2_samples", 32'(bus.samples), 32'b1010);
    cycle();

    // 3: consumer stalls for 7 cycles; mask change mid-scan is ignored
    p = 4'b0110; bus.ch_mask = 4'b0110; bus.frame_ready = 1'b0; bus.start = 1'b1;
    cycle();
    bus.start = 1'b0; bus.ch_mask = 4'b0000;
    wait_valid(n);
    check("t3_latency", 32'(n), 32'd10);
    held = bus.samples;
    for (int i = 0; i < 7; i++) begin
      bus.stop = (i == 3);
      cycle();
      check("t3_hold_valid", 32'(bus.frame_valid), 32'd1);
      check("t3_hold_samples", 32'(bus.samples), 32'(held));
    end
    bus.stop = 1'b0; bus.frame_ready = 1'b1;
    cycle();
    check("t3_to_idle", 32'(bus.busy), 32'd0);

    // 4: stop mid-scan, start with empty mask, start+stop together
    p = 4'b1111; bus.ch_mask = 4'b1111; bus.start = 1'b1;
    cycle();
    bus.start = 1'b0;
    repeat (6) cycle();
    bus.stop = 1'b1;
    cycle();
    bus.stop = 1'b0;
    check("t4_stop_busy", 32'(bus.busy), 32'd0);
    check("t4_stop_samples", 32'(bus.samples), 32'd0);
    repeat (25) cycle();
    bus.ch_mask = 4'd0; bus.start = 1'b1;
    repeat (3) cycle();
    check("t4_empty_busy", 32'(bus.busy), 32'd0);
    bus.ch_mask = 4'b0100; bus.stop = 1'b1;
    cycle();
    check("t4_start_stop", 32'(bus.busy), 32'd0);
    bus.start = 1'b0; bus.stop = 1'b0;

    // 5: async reset mid-SETTLE and mid-DONE
    bus.ch_mask = 4'b1111; bus.start = 1'b1;
    cycle();
    bus.start = 1'b0;
    repeat (7) cycle();
    async_reset("t5_settle");
    bus.ch_mask = 4'b1000; bus.frame_ready = 1'b0; bus.start = 1'b1;
    cycle();
    bus.start = 1'b0;
    wait_valid(n);
    check("t5_reach_done", 32'(bus.frame_valid), 32'd1);
    async_reset("t5_done");

`ifdef MUX_SCAN_CONTINUOUS_EN
    // 6: back-to-back frames every 11 cycles
    bus.ch_mask = 4'b0011; bus.frame_ready = 1'b1; bus.start = 1'b1; p = 4'b0010;
    cycle();
    bus.start = 1'b0;
    prev_v = 1'b0;
    for (int i = 0; i < 45; i++) begin
      cycle();
      check("t6_busy", 32'(bus.busy), 32'd1);
      if (bus.frame_valid && !prev_v) rises.push_back(i);
      prev_v = bus.frame_valid;
    end
    check("t6_pulses", 32'(rises.size() >= 3), 32'd1);
    if (rises.size() >= 3) begin
      check("t6_period_a", 32'(rises[1] - rises[0]), 32'd11);
      check("t6_period_b", 32'(rises[2] - rises[1]), 32'd11);
    end
    bus.ch_mask = 4'd0;
    repeat (12) cycle();
    check("t6_stop", 32'(bus.busy), 32'd0);
`endif

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      p               = 4'($urandom);
      bus.start       = ($urandom_range(0, 3) == 0);
      bus.stop        = ($urandom_range(0, 40) == 0);
      bus.ch_mask     = 4'($urandom);
      bus.frame_ready = ($urandom_range(0, 2) != 0);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
